alu_pipe: RTL and testbench

Sequential, handshaked successor to the combinational parametrised ALU. It accepts one operation per transfer on a valid/ready input port and returns a registered result with a full flag set (carry, zero, negative, overflow, illegal) on a valid/ready output port. Single-cycle units (add/sub/logic/shift) complete in one cycle. MUL runs as an iterative shift-add over DATA_WIDTH cycles. The block sits between the decode stage and writeback, where back-pressure from writeback must be honoured.

---
 rtl/alu_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_alu_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle add/sub/logic/shift units plus an iterative
// shift-add multiplier, with a registered result and flags held under back-pressure.
module alu_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_BITS = $clog2(DATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  input  logic [4:0]                opcode,
  input  logic [SHIFT_BITS-1:0]     shift_amount,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     result,
  output logic [2*DATA_WIDTH-1:0]   mult_result,
  output logic                      carry_out,
  output logic                      zero,
  output logic                      negative,
  output logic                      overflow,
  output logic                      illegal_op
);

  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [4:0] OP_ADD  = 5'b00_000;
  localparam logic [4:0] OP_SUB  = 5'b00_001;
  localparam logic [4:0] OP_INC  = 5'b00_010;
  localparam logic [4:0] OP_DEC  = 5'b00_011;
  localparam logic [4:0] OP_MUL  = 5'b00_100;
  localparam logic [4:0] OP_AND  = 5'b01_000;
  localparam logic [4:0] OP_OR   = 5'b01_001;
  localparam logic [4:0] OP_XOR  = 5'b01_010;
  localparam logic [4:0] OP_NOT  = 5'b01_011;
  localparam logic [4:0] OP_NAND = 5'b01_100;
  localparam logic [4:0] OP_NOR  = 5'b01_101;
  localparam logic [4:0] OP_XNOR = 5'b01_110;
  localparam logic [4:0] OP_SLL  = 5'b10_000;
  localparam logic [4:0] OP_SRL  = 5'b10_001;
  localparam logic [4:0] OP_SRA  = 5'b10_010;
  localparam logic [4:0] OP_ROL  = 5'b10_011;
  localparam logic [4:0] OP_ROR  = 5'b10_100;

  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);
  localparam logic [SHIFT_BITS-1:0] CNT_LAST = SHIFT_BITS'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t                  state_q, state_d;
  logic [SHIFT_BITS-1:0]   cnt_q, cnt_d;
  logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*DATA_WIDTH-1:0] acc_q, acc_d;

  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [2*DATA_WIDTH-1:0] mult_result_q, mult_result_d;
  logic                    carry_q, carry_d;
  logic                    zero_q, zero_d;
  logic                    negative_q, negative_d;
  logic                    overflow_q, overflow_d;
  logic                    illegal_q, illegal_d;

  logic                    accept;
  logic [DATA_WIDTH-1:0]   op_b;
  logic [DATA_WIDTH:0]     sum_w, dif_w;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_c, alu_v, alu_ill;
  logic [2*DATA_WIDTH-1:0] acc_sum;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle units, evaluated straight from the live operands at the accept edge.
  // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    op_b    = (opcode == OP_INC || opcode == OP_DEC) ? ONE : b;
    sum_w   = {1'b0, a} + {1'b0, op_b};
    dif_w   = {1'b0, a} - {1'b0, op_b};
    case (opcode)
      OP_ADD, OP_INC: begin
        alu_res = sum_w[MSB:0];
        alu_c   = sum_w[DATA_WIDTH];
        alu_v   = (a[MSB] == op_b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_SUB, OP_DEC: begin
        alu_res = dif_w[MSB:0];
        alu_c   = dif_w[DATA_WIDTH];
        alu_v   = (a[MSB] != op_b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_MUL:  alu_res = '0;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_NAND: alu_res = ~(a & b);
      OP_NOR:  alu_res = ~(a | b);
      OP_XNOR: alu_res = ~(a ^ b);
      OP_SLL:  alu_res = a << shift_amount;
      OP_SRL:  alu_res = a >> shift_amount;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shift_amount);
      // A shift of DATA_WIDTH yields 0, so a zero distance returns a unchanged.
      OP_ROL:  alu_res = (a << shift_amount) | (a >> (DATA_WIDTH - int'(shift_amount)));
      OP_ROR:  alu_res = (a >> shift_amount) | (a << (DATA_WIDTH - int'(shift_amount)));
      default: alu_ill = 1'b1;
    endcase
  end

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    acc_d         = acc_q;
    out_valid_d   = out_valid_q;
    result_d      = result_q;
    mult_result_d = mult_result_q;
    carry_d       = carry_q;
    zero_d        = zero_q;
    negative_d    = negative_q;
    overflow_d    = overflow_q;
    illegal_d     = illegal_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && opcode == OP_MUL) begin
          state_d     = MUL_BUSY;
          cnt_d       = '0;
          mcand_d     = {{DATA_WIDTH{1'b0}}, a};
          mplier_d    = b;
          acc_d       = '0;
          out_valid_d = 1'b0;
        end else if (accept) begin
          out_valid_d   = 1'b1;
          result_d      = alu_res;
          mult_result_d = '0;
          carry_d       = alu_c;
          overflow_d    = alu_v;
          illegal_d     = alu_ill;
          zero_d        = !alu_ill && (alu_res == '0);
          negative_d    = !alu_ill && alu_res[MSB];
        end
      end
      MUL_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHIFT_BITS'(1);
        if (cnt_q == CNT_LAST) begin
          state_d       = IDLE;
          cnt_d         = '0;
          out_valid_d   = 1'b1;
          mult_result_d = acc_sum;
          result_d      = acc_sum[MSB:0];
          carry_d       = |acc_sum[2*DATA_WIDTH-1:DATA_WIDTH];
          zero_d        = (acc_sum[MSB:0] == '0);
          negative_d    = acc_sum[MSB];
          overflow_d    = 1'b0;
          illegal_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  // NOTE: the multiplier working registers are reset too, so an aborted MUL leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      acc_q         <= '0;
      out_valid_q   <= 1'b0;
      result_q      <= '0;
      mult_result_q <= '0;
      carry_q       <= 1'b0;
      zero_q        <= 1'b0;
      negative_q    <= 1'b0;
      overflow_q    <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      acc_q         <= acc_d;
      out_valid_q   <= out_valid_d;
      result_q      <= result_d;
      mult_result_q <= mult_result_d;
      carry_q       <= carry_d;
      zero_q        <= zero_d;
      negative_q    <= negative_d;
      overflow_q    <= overflow_d;
      illegal_q     <= illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign mult_result = mult_result_q;
  assign carry_out   = carry_q;
  assign zero        = zero_q;
  assign negative    = negative_q;
  assign overflow    = overflow_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a reference model queues expected results at
// input transfer and the monitor compares them at each output transfer.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [4:0]  opcode;
  logic [4:0]  shift_amount;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [63:0] mult_result;
  logic        carry_out, zero, negative, overflow, illegal_op;

  int n_cmp = 0;
  int n_err = 0;
  bit rand_bp = 1'b0;

  typedef struct packed {
    logic [31:0] res;
    logic [63:0] mres;
    logic        c, z, n, v, ill;
  } exp_t;

  exp_t sb[$];

  alu_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .shift_amount(shift_amount),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .mult_result(mult_result), .carry_out(carry_out), .zero(zero),
    .negative(negative), .overflow(overflow), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic [4:0] s);
    exp_t e;
    logic [32:0] t;
    logic [31:0] r;
    e = '0;
    case (op)
      5'b00_000: begin t = {1'b0, x} + {1'b0, y}; e.res = t[31:0]; e.c = t[32];
                       e.v = (x[31] == y[31]) && (e.res[31] != x[31]); end
      5'b00_001: begin e.res = x - y; e.c = (x < y);
                       e.v = (x[31] != y[31]) && (e.res[31] != x[31]); end
      5'b00_010: begin e.res = x + 32'd1; e.c = (x == 32'hFFFF_FFFF); e.v = (x == 32'h7FFF_FFFF); end
      5'b00_011: begin e.res = x - 32'd1; e.c = (x == 32'd0); e.v = (x == 32'h8000_0000); end
      5'b00_100: begin e.mres = {32'd0, x} * {32'd0, y}; e.res = e.mres[31:0]; e.c = |e.mres[63:32]; end
      5'b01_000: e.res = x & y;
      5'b01_001: e.res = x | y;
      5'b01_010: e.res = x ^ y;
      5'b01_011: e.res = ~x;
      5'b01_100: e.res = ~(x & y);
      5'b01_101: e.res = ~(x | y);
      5'b01_110: e.res = ~(x ^ y);
      5'b10_000: e.res = x << s;
      5'b10_001: e.res = x >> s;
      5'b10_010: e.res = $unsigned($signed(x) >>> s);
      5'b10_011: begin for (int i = 0; i < 32; i++) r[(i + int'(s)) % 32] = x[i]; e.res = r; end
      5'b10_100: begin for (int i = 0; i < 32; i++) r[i] = x[(i + int'(s)) % 32]; e.res = r; end
      default:   e.ill = 1'b1;
    endcase
    if (!e.ill) begin
      e.z = (e.res == 32'd0);
      e.n = e.res[31];
    end
    return e;
  endfunction

  // Monitor: sampled on the falling edge, where both sides are settled.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_valid", out_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_result", result, e.res);
          check("sb_mult_result", mult_result, e.mres);
          check("sb_carry", carry_out, e.c);
          check("sb_zero", zero, e.z);
          check("sb_negative", negative, e.n);
          check("sb_overflow", overflow, e.v);
          check("sb_illegal", illegal_op, e.ill);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(opcode, a, b, shift_amount));
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [4:0] s);
    int n;
    n = 0;
    opcode = op; a = x; b = y; shift_amount = s; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) check("send_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e_and, e_xor;
    bit   seen;
    int   n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; opcode = '0; shift_amount = '0;

    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'd0);
    check("rst_mult_result", mult_result, 64'd0);
    check("rst_flags", {carry_out, zero, negative, overflow, illegal_op}, 5'd0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Arithmetic corners, then a MUL with its busy window timed.
    send(5'b00_000, 32'hFFFF_FFFF, 32'd1, 5'd0);
    send(5'b00_001, 32'h8000_0000, 32'd1, 5'd0);
    send(5'b00_100, 32'd65536, 32'd65536, 5'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check($sformatf("mul_busy_ready_%0d", i), in_ready, 1'b0);
    end
    @(negedge clk);
    check("mul_done_valid", out_valid, 1'b1);
    check("mul_done_product", mult_result, 64'h1_0000_0000);
    @(posedge clk); #1;

    // Back-to-back rotate and arithmetic shift keep out_valid continuously high.
    send(5'b10_100, 32'h0000_0001, 32'd0, 5'd1);
    check("b2b_valid_first", out_valid, 1'b1);
    send(5'b10_010, 32'hF000_0000, 32'd0, 5'd4);
    check("b2b_valid_second", out_valid, 1'b1);
    check("b2b_result_second", result, 32'hFF00_0000);
    idle(1);
    check("valid_falls_after_retire", out_valid, 1'b0);

    // Back-pressure: AND held five cycles, queued XOR accepted on the retiring edge.
    out_ready = 1'b0;
    e_and = model(5'b01_000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    e_xor = model(5'b01_010, 32'hAAAA_5555, 32'h0F0F_0F0F, 5'd0);
    send(5'b01_000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    opcode = 5'b01_010; a = 32'hAAAA_5555; b = 32'h0F0F_0F0F; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_valid", out_valid, 1'b1);
      check("hold_result", result, e_and.res);
      check("hold_flags", {carry_out, zero, negative, overflow, illegal_op},
            {e_and.c, e_and.z, e_and.n, e_and.v, e_and.ill});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("queued_xor_valid", out_valid, 1'b1);
    check("queued_xor_result", result, e_xor.res);
    idle(1);

    // Boundary shifts, remaining logic ops and illegal codes.
    send(5'b10_000, 32'h1234_5678, 32'd0, 5'd0);
    send(5'b10_010, 32'h8000_0000, 32'd0, 5'd31);
    send(5'b10_011, 32'h8000_0001, 32'd0, 5'd31);
    send(5'b10_100, 32'h1234_5678, 32'd0, 5'd0);
    send(5'b00_011, 32'd0, 32'd0, 5'd0);
    send(5'b00_010, 32'h7FFF_FFFF, 32'd0, 5'd0);
    send(5'b01_011, 32'h0000_FFFF, 32'd0, 5'd0);
    send(5'b01_100, 32'hFFFF_0000, 32'hFF00_FF00, 5'd0);
    send(5'b01_101, 32'd0, 32'd0, 5'd0);
    send(5'b01_110, 32'h1234_5678, 32'h1234_5678, 5'd0);
    send(5'b01_001, 32'h00FF_0000, 32'h0000_00FF, 5'd0);
    send(5'b11_111, 32'hDEAD_BEEF, 32'h1, 5'd3);
    check("illegal_flag", illegal_op, 1'b1);
    check("illegal_result", result, 32'd0);
    send(5'b01_111, 32'h1, 32'h1, 5'd0);
    send(5'b10_101, 32'h1, 32'h1, 5'd1);
    idle(2);

    // Reset during MUL aborts it.
    send(5'b00_100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    idle(9);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_result", result, 32'd0);
    check("abort_mult_result", mult_result, 64'd0);
    check("abort_flags", {carry_out, zero, negative, overflow, illegal_op}, 5'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("abort_no_valid", seen, 1'b0);
    @(posedge clk); #1;

    // Random ops under random back-pressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(5'($urandom_range(0, 31)), $urandom, $urandom, 5'($urandom_range(0, 31)));
      idle($urandom_range(0, 1));
    end
    rand_bp = 1'b0;
    idle(1);
    out_ready = 1'b1;

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
